// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: branch codes from the
// decoder and the fetch FSM state encoding.
package fetch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ready handshake between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluator: compares the IF/ID operands as signed values
// according to the decoder's 3-bit branch code.
module branch_cmp
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        branch,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] rt_val,
  output logic              cond
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val[ADDR_W-1];
  assign rs_zero = (rs_val == '0);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    cond = 1'b0;
    case (branch)
      BR_BEQ:  cond = (rs_val == rt_val);
      BR_BNE:  cond = (rs_val != rt_val);
      BR_BGEZ: cond = ~rs_neg;
      BR_BGTZ: cond = ~rs_neg & ~rs_zero;
      BR_BLEZ: cond = rs_neg | rs_zero;
      BR_BLTZ: cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over the imem handshake into a skid buffer
// and the IF/ID register, and resolves branches presented by the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_if.master            imem,
  input  logic               stall,
  input  logic [2:0]         branch,
  input  logic [ADDR_W-1:0]  branch_imm,
  input  logic [ADDR_W-1:0]  rs_val,
  input  logic [ADDR_W-1:0]  rt_val,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               valid,
  output logic [5:0]         opcode,
  output logic [4:0]         rt_field,
  output logic               redirect
);

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  issue_addr;
  logic [INSTR_W-1:0] sk_instr;
  logic [ADDR_W-1:0]  sk_pc;
  logic               sk_full;

  logic cond;
  logic consume;
  logic taken;
  logic fire;
  logic issue;
  logic word_to_ifid;

  branch_cmp #(.ADDR_W(ADDR_W)) u_cmp (
    .branch (branch),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cond   (cond)
  );

  assign consume  = valid & ~stall;
  assign taken    = consume & cond;
  assign redirect = taken;
  assign pc_inc   = pc + ADDR_W'(4);
  assign target   = instr_pc + ADDR_W'(4) + (branch_imm << 2);
  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];

  // A returning word lands in IF/ID only when the skid is empty and IF/ID is free.
  assign word_to_ifid = (~valid | consume) & ~sk_full;

  assign imem.req  = (state != IDLE);
  assign imem.addr = addr_q;

  always_comb begin
    state_nxt  = state;
    fire       = 1'b0;
    issue      = 1'b0;
    issue_addr = pc;
    case (state)
      IDLE: begin
        if (!taken && !sk_full) begin
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (imem.ready) begin
          if (taken) begin
            state_nxt = IDLE;
          end else begin
            fire = 1'b1;
            if (word_to_ifid) begin
              issue      = 1'b1;
              issue_addr = pc_inc;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else if (taken) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem.ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
      valid    <= 1'b0;
      // NOTE: skid payload is reset too; it is only two words and keeps the datapath free of X.
      sk_instr <= '0;
      sk_pc    <= '0;
      sk_full  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (taken)     pc <= target;
      else if (fire) pc <= pc_inc;

      if (issue) addr_q <= issue_addr;

      // IF/ID: a taken branch flushes; otherwise the skid word has priority.
      if (taken) begin
        valid <= 1'b0;
      end else if (consume && sk_full) begin
        instr    <= sk_instr;
        instr_pc <= sk_pc;
        valid    <= 1'b1;
      end else if (fire && word_to_ifid) begin
        instr    <= imem.rdata;
        instr_pc <= pc;
        valid    <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end

      if (taken) begin
        sk_full <= 1'b0;
      end else if (fire && !word_to_ifid) begin
        sk_instr <= imem.rdata;
        sk_pc    <= pc;
        sk_full  <= 1'b1;
      end else if (consume && sk_full) begin
        sk_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branches, skid fill under
// stall, signed compare table, DROP path and reset during DROP.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  branch;
  logic [31:0] branch_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        valid;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic        redirect;

  int errors = 0;
  int checks = 0;

  fetch_if #(.ADDR_W(32)) imem ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem),
    .stall      (stall),
    .branch     (branch),
    .branch_imm (branch_imm),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .valid      (valid),
    .opcode     (opcode),
    .rt_field   (rt_field),
    .redirect   (redirect)
  );

  always #5 clk = ~clk;

  // Memory contents: opcode 0x23, rt_field = addr[6:2].
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h8C00_0000 | (a << 14);
  endfunction

  assign imem.rdata = word_of(imem.addr);

  typedef struct {
    logic [2:0]  br;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stl;
    logic        exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      32'(imem.req), 32'h0);
    check({tag, "_addr"},     imem.addr,     32'h0);
    check({tag, "_instr"},    instr,         32'h0);
    check({tag, "_instr_pc"}, instr_pc,      32'h0);
    check({tag, "_valid"},    32'(valid),    32'h0);
    check({tag, "_redirect"}, 32'(redirect), 32'h0);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc);
    check({tag, "_valid"},    32'(valid), 32'h1);
    check({tag, "_instr_pc"}, instr_pc,   pc);
    check({tag, "_instr"},    instr,      word_of(pc));
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, 32'(imem.req), 32'(req));
    if (req) check({tag, "_addr"}, imem.addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{BR_BLTZ, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1};
    vecs[1]  = '{BR_BLEZ, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1};
    vecs[2]  = '{BR_BGEZ, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{BR_BGTZ, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{BR_BGEZ, 32'h0,         32'h0, 1'b0, 1'b1};
    vecs[5]  = '{BR_BLEZ, 32'h0,         32'h0, 1'b0, 1'b1};
    vecs[6]  = '{BR_BGTZ, 32'h0,         32'h0, 1'b0, 1'b0};
    vecs[7]  = '{BR_BLTZ, 32'h0,         32'h0, 1'b0, 1'b0};
    vecs[8]  = '{BR_BGTZ, 32'h1,         32'h0, 1'b0, 1'b1};
    vecs[9]  = '{BR_BGEZ, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{BR_BLTZ, 32'h8000_0000, 32'h0, 1'b0, 1'b1};
    vecs[11] = '{BR_BEQ,  32'h5,         32'h5, 1'b0, 1'b1};
    vecs[12] = '{BR_BEQ,  32'h5,         32'h6, 1'b0, 1'b0};
    vecs[13] = '{BR_BNE,  32'h5,         32'h6, 1'b0, 1'b1};
    vecs[14] = '{BR_BNE,  32'h5,         32'h5, 1'b0, 1'b0};
    vecs[15] = '{3'b111,  32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0};
    vecs[16] = '{BR_NONE, 32'h0,         32'h0, 1'b0, 1'b0};
    vecs[17] = '{BR_BEQ,  32'h9,         32'h9, 1'b1, 1'b0};

    reset      = 1'b1;
    stall      = 1'b0;
    branch     = BR_NONE;
    branch_imm = 32'h0;
    rs_val     = 32'h0;
    rt_val     = 32'h0;
    imem.ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // Zero-wait sequential fetch
    reset = 1'b0;
    @(negedge clk);
    check_req("seq_first", 1'b1, 32'h0);
    check("seq_first_valid", 32'(valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_ifid($sformatf("seq%0d", k), 32'(4 * k));
      check_req($sformatf("seq%0d", k), 1'b1, 32'(4 * k + 4));
      check($sformatf("seq%0d_opcode", k), 32'(opcode), 32'h23);
      check($sformatf("seq%0d_rt_field", k), 32'(rt_field), 32'(k));
    end

    // Taken beq at 0x10, imm 3 -> target 0x20; word at 0x14 dropped
    branch = BR_BEQ; branch_imm = 32'd3; rs_val = 32'd5; rt_val = 32'd5;
    #1 check("beq_redirect", 32'(redirect), 32'h1);
    @(negedge clk);
    branch = BR_NONE;
    #1 check("beq_redirect_pulse", 32'(redirect), 32'h0);
    check("beq_flush_valid", 32'(valid), 32'h0);
    check_req("beq_idle", 1'b0, 32'h0);
    @(negedge clk);
    check_req("beq_target", 1'b1, 32'h20);
    @(negedge clk);
    check_ifid("beq_land", 32'h20);
    check_req("beq_next", 1'b1, 32'h24);

    // Not-taken bne
    branch = BR_BNE; rs_val = 32'd7; rt_val = 32'd7;
    #1 check("bne_redirect", 32'(redirect), 32'h0);
    @(negedge clk);
    branch = BR_NONE;
    check_ifid("bne_next", 32'h24);
    check_req("bne_next", 1'b1, 32'h28);

    // Stall for 4 cycles: one extra word into the skid, then no requests
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_req($sformatf("stall%0d", i), 1'b0, 32'h0);
      check_ifid($sformatf("stall%0d", i), 32'h24);
    end
    stall = 1'b0;
    @(negedge clk);
    check_ifid("unstall_skid", 32'h28);
    check_req("unstall_skid", 1'b0, 32'h0);
    @(negedge clk);
    check("unstall_bubble_valid", 32'(valid), 32'h0);
    check_req("unstall_refetch", 1'b1, 32'h2C);
    @(negedge clk);
    check_ifid("unstall_next", 32'h2C);
    check_req("unstall_next", 1'b1, 32'h30);

    // Signed-compare table with IF/ID parked on 0x2C (skid holds 0x30)
    stall = 1'b1;
    @(negedge clk);
    check_ifid("park", 32'h2C);
    check_req("park", 1'b0, 32'h0);
    for (int i = 0; i < 18; i++) begin
      branch = vecs[i].br;
      rs_val = vecs[i].rs;
      rt_val = vecs[i].rt;
      stall  = vecs[i].stl;
      #1 check($sformatf("cmp%0d_redirect", i), 32'(redirect), 32'(vecs[i].exp));
      #1;
      stall  = 1'b1;
      branch = BR_NONE;
      @(negedge clk);
    end
    check_ifid("park_after", 32'h2C);

    // DROP path: memory slow, branch while request outstanding
    imem.ready = 1'b0;
    stall      = 1'b0;
    @(negedge clk);
    check_ifid("drop_setup", 32'h30);
    stall = 1'b1;
    @(negedge clk);
    check_req("drop_issue", 1'b1, 32'h34);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_req($sformatf("drop_wait%0d", i), 1'b1, 32'h34);
      check_ifid($sformatf("drop_wait%0d", i), 32'h30);
    end
    stall = 1'b0; branch = BR_BEQ; branch_imm = 32'hFFFF_FFFE; rs_val = 32'd1; rt_val = 32'd1;
    #1 check("drop_redirect", 32'(redirect), 32'h1);
    @(negedge clk);
    branch = BR_NONE;
    #1 check("drop_flush_valid", 32'(valid), 32'h0);
    check_req("drop_hold0", 1'b1, 32'h34);
    @(negedge clk);
    check_req("drop_hold1", 1'b1, 32'h34);
    imem.ready = 1'b1;
    @(negedge clk);
    check_req("drop_done", 1'b0, 32'h0);
    check("drop_discard_valid", 32'(valid), 32'h0);
    @(negedge clk);
    check_req("drop_target", 1'b1, 32'h2C);
    @(negedge clk);
    check_ifid("drop_land", 32'h2C);
    check_req("drop_land", 1'b1, 32'h30);

    // Reset asserted while in DROP
    imem.ready = 1'b0;
    branch = BR_BEQ; branch_imm = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
    #1 check("rdrop_redirect", 32'(redirect), 32'h1);
    @(negedge clk);
    branch = BR_NONE;
    check_req("rdrop_in_drop", 1'b1, 32'h30);
    #1 reset = 1'b1;
    #1 check_reset_outputs("rdrop");
    @(negedge clk);
    reset      = 1'b0;
    imem.ready = 1'b1;
    @(negedge clk);
    check_req("rdrop_restart", 1'b1, 32'h0);
    @(negedge clk);
    check_ifid("rdrop_first", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
